// File: rtl/param_register_file.sv
// ----------------------------------------------------------------------------
// param_register_file
//   Parametrised integer register file for the single-cycle CPU.
//   - x0 is hardwired to zero; register 2 resets to SP_INIT.
//   - One busy bit per register. A mark sets it and a committing write
//     clears it. When both hit the same register on one edge, the mark wins.
//   - Sticky halt flag. It is set by ecall when HALT_REG holds HALT_CODE and
//     is cleared only by reset. While halted, writes and marks are dropped.
//   - Optional macro RF_BYPASS_EN: the same-cycle write data is forwarded to
//     the read ports, to the busy outputs and to the halt check.
//
// Parameters: XLEN, NUM_REGS (power of two, >= 16), AW (derived),
//             SP_INIT, HALT_REG, HALT_CODE
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   rs1, rs2              read addresses
//   rs1_dout, rs2_dout    combinational read data
//   rs1_busy, rs2_busy    combinational pending-write flags
//   rd, rd_din            write address / data
//   write_enable          commit rd_din to rd on this edge
//   mark_valid, mark_rd   reserve a pending write to mark_rd
//   ecall                 ecall in decode this cycle
//   is_halted             registered, sticky halt flag
// ----------------------------------------------------------------------------
module param_register_file #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    localparam int AW       = $clog2(NUM_REGS),
    parameter     SP_INIT   = 32'h2ffc,
    parameter int HALT_REG  = 17,
    parameter     HALT_CODE = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_dout,
    output logic [XLEN-1:0] rs2_dout,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_din,
    input  logic            write_enable,
    input  logic            mark_valid,
    input  logic [AW-1:0]   mark_rd,
    input  logic            ecall,
    output logic            is_halted
);

    localparam logic [XLEN-1:0] SP_VAL   = XLEN'(SP_INIT);
    localparam logic [XLEN-1:0] HALT_VAL = XLEN'(HALT_CODE);
    localparam logic [AW-1:0]   HALT_IDX = AW'(HALT_REG);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                halted;
    logic                wr_ok;
    logic                mk_ok;
    logic [XLEN-1:0]     x_halt;

    // Both qualifiers exclude x0, so neither regs[0] nor busy[0] ever leaves zero.
    assign wr_ok     = write_enable && !halted && (rd != '0);
    assign mk_ok     = mark_valid && !halted && (mark_rd != '0);
    assign is_halted = halted;

    always_comb begin
        rs1_dout = (rs1 == '0) ? '0 : regs[rs1];
        rs2_dout = (rs2 == '0) ? '0 : regs[rs2];
        rs1_busy = busy[rs1];
        rs2_busy = busy[rs2];
        x_halt   = (HALT_IDX == '0) ? '0 : regs[HALT_IDX];
`ifdef RF_BYPASS_EN
        if (wr_ok && (rd == rs1)) begin
            rs1_dout = rd_din;
            rs1_busy = mk_ok && (mark_rd == rs1);
        end
        if (wr_ok && (rd == rs2)) begin
            rs2_dout = rd_din;
            rs2_busy = mk_ok && (mark_rd == rs2);
        end
        if (wr_ok && (rd == HALT_IDX)) begin
            x_halt = rd_din;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 2) ? SP_VAL : '0;
            end
            busy   <= '0;
            halted <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[rd] <= rd_din;
                busy[rd] <= 1'b0;
            end
            // Placed after the clear so that a newer producer overrides a
            // completing write to the same register.
            if (mk_ok) begin
                busy[mark_rd] <= 1'b1;
            end
            if (ecall && !halted && (x_halt == HALT_VAL)) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Default 32x32 instance
    logic [4:0]  rs1, rs2, rd, mark_rd;
    logic [31:0] rs1_dout, rs2_dout, rd_din;
    logic        rs1_busy, rs2_busy, write_enable, mark_valid, ecall, is_halted;

    // 64-bit, 16-register instance
    logic [3:0]  w_rs1, w_rs2, w_rd, w_mark_rd;
    logic [63:0] w_rs1_dout, w_rs2_dout, w_rd_din;
    logic        w_rs1_busy, w_rs2_busy, w_write_enable, w_mark_valid, w_ecall, w_is_halted;

    int total = 0;
    int bad   = 0;

    param_register_file dut (
        .clk(clk), .reset_n(reset_n),
        .rs1(rs1), .rs2(rs2), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd(rd), .rd_din(rd_din), .write_enable(write_enable),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .ecall(ecall), .is_halted(is_halted)
    );

    param_register_file #(
        .XLEN(64), .NUM_REGS(16), .HALT_REG(9), .HALT_CODE(64'h0000_0001_0000_000a)
    ) dut64 (
        .clk(clk), .reset_n(reset_n),
        .rs1(w_rs1), .rs2(w_rs2), .rs1_dout(w_rs1_dout), .rs2_dout(w_rs2_dout),
        .rs1_busy(w_rs1_busy), .rs2_busy(w_rs2_busy),
        .rd(w_rd), .rd_din(w_rd_din), .write_enable(w_write_enable),
        .mark_valid(w_mark_valid), .mark_rd(w_mark_rd),
        .ecall(w_ecall), .is_halted(w_is_halted)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; mark_rd = '0; rd_din = '0;
        write_enable = 1'b0; mark_valid = 1'b0; ecall = 1'b0;
        w_rs1 = '0; w_rs2 = '0; w_rd = '0; w_mark_rd = '0; w_rd_din = '0;
        w_write_enable = 1'b0; w_mark_valid = 1'b0; w_ecall = 1'b0;

        // Reset held for two edges
        tick();
        tick();
        reset_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            rs2 = 5'(r);
            #1;
            check("reset_rs1", 64'(rs1_dout), (r == 2) ? 64'h2ffc : 64'h0);
            check("reset_rs2", 64'(rs2_dout), (r == 2) ? 64'h2ffc : 64'h0);
            check("reset_busy1", 64'(rs1_busy), 64'h0);
            check("reset_busy2", 64'(rs2_busy), 64'h0);
        end
        check("reset_halt", 64'(is_halted), 64'h0);

        // Write to x0 is discarded
        rd = 5'd0; rd_din = 32'hdeadbeef; write_enable = 1'b1; rs1 = 5'd0;
        tick();
        write_enable = 1'b0;
        #1;
        check("x0_zero", 64'(rs1_dout), 64'h0);

        // Write x5
        rd = 5'd5; rd_din = 32'hdeadbeef; write_enable = 1'b1; rs1 = 5'd5;
        #1;
`ifdef RF_BYPASS_EN
        check("x5_same_cycle", 64'(rs1_dout), 64'hdeadbeef);
`else
        check("x5_same_cycle", 64'(rs1_dout), 64'h0);
`endif
        tick();
        write_enable = 1'b0;
        #1;
        check("x5_after", 64'(rs1_dout), 64'hdeadbeef);

        // Scoreboard: mark x7, write x7 next cycle
        mark_valid = 1'b1; mark_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
        tick();
        mark_valid = 1'b0;
        #1;
        check("busy_set1", 64'(rs1_busy), 64'h1);
        check("busy_set2", 64'(rs2_busy), 64'h1);
        rd = 5'd7; rd_din = 32'h77; write_enable = 1'b1;
        #1;
`ifdef RF_BYPASS_EN
        check("busy_bypass", 64'(rs1_busy), 64'h0);
`else
        check("busy_nobypass", 64'(rs1_busy), 64'h1);
`endif
        tick();
        write_enable = 1'b0;
        #1;
        check("busy_clear", 64'(rs1_busy), 64'h0);
        check("x7_data", 64'(rs1_dout), 64'h77);

        // Same-cycle mark and write: mark wins
        rd = 5'd7; rd_din = 32'h88; write_enable = 1'b1;
        mark_valid = 1'b1; mark_rd = 5'd7;
        tick();
        write_enable = 1'b0; mark_valid = 1'b0;
        #1;
        check("busy_set_wins", 64'(rs1_busy), 64'h1);
        check("x7_data2", 64'(rs1_dout), 64'h88);

        // Mark x0 has no effect
        mark_valid = 1'b1; mark_rd = 5'd0; rs2 = 5'd0;
        tick();
        mark_valid = 1'b0;
        #1;
        check("busy_x0", 64'(rs2_busy), 64'h0);

        // Ecall with x17 = 9: no halt
        rd = 5'd17; rd_din = 32'd9; write_enable = 1'b1;
        tick();
        write_enable = 1'b0; ecall = 1'b1;
        tick();
        ecall = 1'b0;
        #1;
        check("no_halt_9", 64'(is_halted), 64'h0);

        // Ecall with x17 = 10: halt
        rd = 5'd17; rd_din = 32'd10; write_enable = 1'b1;
        tick();
        write_enable = 1'b0; ecall = 1'b1;
        #1;
        check("halt_not_yet", 64'(is_halted), 64'h0);
        tick();
        ecall = 1'b0;
        #1;
        check("halt_set", 64'(is_halted), 64'h1);

        // While halted: write and mark ignored, reads live
        rd = 5'd8; rd_din = 32'd5; write_enable = 1'b1;
        mark_valid = 1'b1; mark_rd = 5'd9;
        tick();
        write_enable = 1'b0; mark_valid = 1'b0;
        rs1 = 5'd8; rs2 = 5'd9;
        #1;
        check("halt_write_ignored", 64'(rs1_dout), 64'h0);
        check("halt_mark_ignored", 64'(rs2_busy), 64'h0);
        rs1 = 5'd17;
        #1;
        check("halt_read_live", 64'(rs1_dout), 64'd10);
        tick();
        check("halt_sticky", 64'(is_halted), 64'h1);

        // Reset in the same cycle as a write to x3
        reset_n = 1'b0; rd = 5'd3; rd_din = 32'h1234; write_enable = 1'b1;
        tick();
        reset_n = 1'b1; write_enable = 1'b0;
        rs1 = 5'd3; rs2 = 5'd7;
        #1;
        check("rst_mid_x3", 64'(rs1_dout), 64'h0);
        check("rst_mid_busy", 64'(rs2_busy), 64'h0);
        check("rst_mid_halt", 64'(is_halted), 64'h0);
        rs2 = 5'd2;
        #1;
        check("rst_mid_sp", 64'(rs2_dout), 64'h2ffc);

        // First edge after reset performs normal write
        rd = 5'd3; rd_din = 32'h1234; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        #1;
        check("post_rst_write", 64'(rs1_dout), 64'h1234);

        // 64-bit / 16-register instance
        w_rs1 = 4'd2;
        #1;
        check("w_sp", w_rs1_dout, 64'h2ffc);
        w_rd = 4'd15; w_rd_din = 64'hfedc_ba98_7654_3210; w_write_enable = 1'b1;
        tick();
        w_write_enable = 1'b0; w_rs1 = 4'd15;
        #1;
        check("w_x15", w_rs1_dout, 64'hfedc_ba98_7654_3210);

        // Low 32 bits match HALT_CODE but upper bits differ: no halt
        w_rd = 4'd9; w_rd_din = 64'h0000_0000_0000_000a; w_write_enable = 1'b1;
        tick();
        w_write_enable = 1'b0; w_ecall = 1'b1;
        tick();
        w_ecall = 1'b0;
        #1;
        check("w_no_halt", 64'(w_is_halted), 64'h0);
        w_rd = 4'd9; w_rd_din = 64'h0000_0001_0000_000a; w_write_enable = 1'b1;
        tick();
        w_write_enable = 1'b0; w_ecall = 1'b1;
        tick();
        w_ecall = 1'b0;
        #1;
        check("w_halt", 64'(w_is_halted), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
